square_ctrl: RTL and testbench
==============================

SQUARE_CTRL -- requirements
Module: square_ctrl

Interface
REQ-001 Parameter H_RES, default 640, active pixels per line.
REQ-002 Parameter V_RES, default 480, active lines per frame.
REQ-003 Parameter SQ_SIZE, default 32, square edge length in pixels.
REQ-004 Parameter SPEED, default 2, pixels moved per axis per update.
REQ-005 Parameters X_INIT and Y_INIT, defaults 0 and 0, square top-left position after reset.
REQ-006 clk_pix  input  1  pixel clock; every flop SHALL be on its rising edge.
REQ-007 rst_pix_n  input  1  reset, asynchronous assert, active-low.
REQ-008 sx  input  10  current horizontal screen position from the sync generator.
REQ-009 sy  input  10  current vertical screen position from the sync generator.
REQ-010 de  input  1  data enable, high in the active area.
REQ-011 enable  input  1  level; high runs the animation, low pauses it.
REQ-012 step  input  1  one-cycle pulse; while paused, requests one motion update.
REQ-013 qx, qy  output  10 each  registered square top-left position.
REQ-014 dx_pos, dy_pos  output  1 each  direction flags; 1 means +x / +y.
REQ-015 in_square  output  1  registered pixel-inside-square flag.
REQ-016 frame_tick  output  1  one-cycle pulse at the start of vertical blanking.
REQ-017 bounce  output  1  one-cycle pulse on any edge reflection.
REQ-018 state  output  2  FSM state encoding: IDLE=0, RUN=1, PAUSE=2.

Function
REQ-019 frame_tick SHALL be high for exactly the one cycle after the cycle in which sx==0 and sy==V_RES.
REQ-020 The FSM SHALL move IDLE->RUN on enable=1, RUN->PAUSE on enable=0, and PAUSE->RUN on enable=1.
REQ-021 In RUN, qx and qy SHALL update in the cycle frame_tick is high; they SHALL never change while de can be high.
REQ-022 In PAUSE, a step pulse SHALL set a pending flag; the next frame_tick SHALL perform one update and clear the flag.
REQ-023 A second step while the pending flag is set SHALL be ignored; at most one update occurs per frame.
REQ-024 If enable=1 and step=1 arrive together in PAUSE, the FSM SHALL enter RUN and discard the step.
REQ-025 Step pulses in IDLE or RUN SHALL be ignored.
REQ-026 X update, dx_pos=1: if qx+SPEED >= H_RES-SQ_SIZE, then qx <= H_RES-SQ_SIZE, dx_pos <= 0, and bounce fires; otherwise qx <= qx+SPEED.
REQ-027 X update, dx_pos=0: if qx <= SPEED, then qx <= 0, dx_pos <= 1, and bounce fires; otherwise qx <= qx-SPEED.
REQ-028 The Y axis SHALL follow the same rules using qy, dy_pos and V_RES.
REQ-029 Comparisons SHALL use 11-bit unsigned arithmetic; no wrap-around is permitted.
REQ-030 A simultaneous X and Y reflection (corner hit) SHALL produce a single bounce pulse.
REQ-031 bounce SHALL be high for exactly the cycle after the update.
REQ-032 in_square SHALL equal de && qx<=sx<qx+SQ_SIZE && qy<=sy<qy+SQ_SIZE, registered, with 1-cycle latency.

Reset
REQ-033 While rst_pix_n=0, outputs SHALL be: state=IDLE, qx=X_INIT, qy=Y_INIT, dx_pos=1, dy_pos=1, in_square=0, frame_tick=0, bounce=0; the pending flag SHALL be 0.
REQ-034 A reset asserted mid-frame or mid-update SHALL take effect immediately, with no partial update retained.
REQ-035 After release, the first frame_tick SHALL require a fresh sx==0, sy==V_RES cycle.

Configuration
REQ-036 With SQUARE_CTRL_COLOR_EN defined, the block SHALL add output rgb (12 bits), reset to 12'hFFF, rotated left by 4 bits on each bounce, and driven to 0 when in_square=0.
REQ-037 Without SQUARE_CTRL_COLOR_EN, the rgb port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-038 Reset, then enable=1 for one full frame -> state=RUN; after the first frame_tick, qx=2 and qy=2.
REQ-039 Preload qx=606, dx_pos=1 via X_INIT=606, run one update -> qx=608, dx_pos=0, bounce pulses once.
REQ-040 X_INIT=1, Y_INIT=1, dx_pos and dy_pos forced to 0 by prior reflection, one update -> qx=0, qy=0, a single bounce pulse, both direction flags=1.
REQ-041 In PAUSE, three step pulses within one frame -> exactly one 2-pixel move at the next frame_tick, then no further moves.
REQ-042 sx=qx+31, sy=qy, de=1 -> in_square=1 next cycle; sx=qx+32 -> in_square=0 next cycle.
REQ-043 Assert rst_pix_n=0 in the cycle frame_tick is high -> qx=X_INIT and bounce=0 with no clock edge required.

Source files
------------

// File: rtl/square_ctrl.sv
// Bouncing-square position controller: moves a square once per frame and flags pixels inside it.
// Optional SQUARE_CTRL_COLOR_EN adds a 12-bit rgb output that rotates its colour on every bounce.
module square_ctrl #(
    parameter int unsigned H_RES   = 640,
    parameter int unsigned V_RES   = 480,
    parameter int unsigned SQ_SIZE = 32,
    parameter int unsigned SPEED   = 2,
    parameter int unsigned X_INIT  = 0,
    parameter int unsigned Y_INIT  = 0
) (
    input  logic       clk_pix,
    input  logic       rst_pix_n,
    input  logic [9:0] sx,
    input  logic [9:0] sy,
    input  logic       de,
    input  logic       enable,
    input  logic       step,
    output logic [9:0] qx,
    output logic [9:0] qy,
    output logic       dx_pos,
    output logic       dy_pos,
    output logic       in_square,
    output logic       frame_tick,
    output logic       bounce,
`ifdef SQUARE_CTRL_COLOR_EN
    output logic [11:0] rgb,
`endif
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2
    } state_e;

    localparam logic [10:0] XMax   = 11'(H_RES - SQ_SIZE);
    localparam logic [10:0] YMax   = 11'(V_RES - SQ_SIZE);
    localparam logic [10:0] Spd    = 11'(SPEED);
    localparam logic [10:0] Sq     = 11'(SQ_SIZE);
    localparam logic [9:0]  VRes   = 10'(V_RES);
    localparam logic [9:0]  XReset = 10'(X_INIT);
    localparam logic [9:0]  YReset = 10'(Y_INIT);

    state_e     state_q, state_d;
    logic [9:0] qx_q, qy_q;
    logic       dx_q, dy_q;
    logic       in_square_q, in_square_d;
    logic       frame_tick_q, frame_tick_d;
    logic       bounce_q, bounce_d;
    logic       pending_q, pending_d;
    logic       upd;
    logic [11:0] x_res, y_res;

    // Returns {reflected, new_dir, new_pos}; all compares in 11 bits so nothing wraps.
    function automatic logic [11:0] axis_next(input logic [9:0] pos, input logic dir,
                                              input logic [10:0] lim);
        logic [10:0] pos_w;
        logic [10:0] sum;
        logic [10:0] dif;
        pos_w = {1'b0, pos};
        sum   = pos_w + Spd;
        dif   = pos_w - Spd;
        if (dir) begin
            if (sum >= lim) axis_next = {1'b1, 1'b0, lim[9:0]};
            else            axis_next = {1'b0, 1'b1, sum[9:0]};
        end else begin
            if (pos_w <= Spd) axis_next = {1'b1, 1'b1, 10'd0};
            else              axis_next = {1'b0, 1'b0, dif[9:0]};
        end
    endfunction

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (enable)  state_d = StRun;
            StRun:   if (!enable) state_d = StPause;
            StPause: if (enable)  state_d = StRun;
            default: state_d = StIdle;
        endcase
    end

    // frame_tick_q is high during the first blanking cycle, so positions move outside de.
    assign upd = frame_tick_q && ((state_q == StRun) || ((state_q == StPause) && pending_q));

    always_comb begin
        pending_d = pending_q;
        if ((state_q != StPause) || enable) pending_d = 1'b0;
        else if (upd)                       pending_d = 1'b0;
        else if (step)                      pending_d = 1'b1;
    end

    always_comb begin
        x_res        = axis_next(qx_q, dx_q, XMax);
        y_res        = axis_next(qy_q, dy_q, YMax);
        bounce_d     = upd && (x_res[11] || y_res[11]);
        frame_tick_d = (sx == 10'd0) && (sy == VRes);
        in_square_d  = de
                    && ({1'b0, sx} >= {1'b0, qx_q}) && ({1'b0, sx} < ({1'b0, qx_q} + Sq))
                    && ({1'b0, sy} >= {1'b0, qy_q}) && ({1'b0, sy} < ({1'b0, qy_q} + Sq));
    end

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            state_q      <= StIdle;
            qx_q         <= XReset;
            qy_q         <= YReset;
            dx_q         <= 1'b1;
            dy_q         <= 1'b1;
            in_square_q  <= 1'b0;
            frame_tick_q <= 1'b0;
            bounce_q     <= 1'b0;
            pending_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_square_q  <= in_square_d;
            frame_tick_q <= frame_tick_d;
            bounce_q     <= bounce_d;
            pending_q    <= pending_d;
            if (upd) begin
                qx_q <= x_res[9:0];
                dx_q <= x_res[10];
                qy_q <= y_res[9:0];
                dy_q <= y_res[10];
            end
        end
    end

`ifdef SQUARE_CTRL_COLOR_EN
    logic [11:0] rgb_q;

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n)    rgb_q <= 12'hFFF;
        else if (bounce_d) rgb_q <= {rgb_q[7:0], rgb_q[11:8]};
    end

    assign rgb = in_square_q ? rgb_q : 12'h000;
`endif

    assign state      = state_q;
    assign qx         = qx_q;
    assign qy         = qy_q;
    assign dx_pos     = dx_q;
    assign dy_pos     = dy_q;
    assign in_square  = in_square_q;
    assign frame_tick = frame_tick_q;
    assign bounce     = bounce_q;

endmodule

// File: tb/tb_square_ctrl.sv
// Bench for square_ctrl: two instances (default start and X_INIT=606) checked every cycle
// against an integer reference model, plus directed literal expectations.
module tb_square_ctrl;

    localparam int H  = 640;
    localparam int V  = 480;
    localparam int SQ = 32;
    localparam int SP = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] sx, sy;
    logic       de, enable, step;

    logic [9:0] a_qx, a_qy, b_qx, b_qy;
    logic       a_dx, a_dy, a_in, a_ft, a_b;
    logic       b_dx, b_dy, b_in, b_ft, b_b;
    logic [1:0] a_st, b_st;
`ifdef SQUARE_CTRL_COLOR_EN
    logic [11:0] a_rgb, b_rgb;
`endif

    logic [26:0] act [2];
    assign act[0] = {a_st, a_qx, a_qy, a_dx, a_dy, a_in, a_ft, a_b};
    assign act[1] = {b_st, b_qx, b_qy, b_dx, b_dy, b_in, b_ft, b_b};

    always #5 clk = ~clk;

    square_ctrl u_a (
        .clk_pix(clk), .rst_pix_n(rst_n), .sx(sx), .sy(sy), .de(de), .enable(enable),
        .step(step), .qx(a_qx), .qy(a_qy), .dx_pos(a_dx), .dy_pos(a_dy), .in_square(a_in),
        .frame_tick(a_ft), .bounce(a_b),
`ifdef SQUARE_CTRL_COLOR_EN
        .rgb(a_rgb),
`endif
        .state(a_st)
    );

    square_ctrl #(.X_INIT(606), .Y_INIT(0)) u_b (
        .clk_pix(clk), .rst_pix_n(rst_n), .sx(sx), .sy(sy), .de(de), .enable(enable),
        .step(step), .qx(b_qx), .qy(b_qy), .dx_pos(b_dx), .dy_pos(b_dy), .in_square(b_in),
        .frame_tick(b_ft), .bounce(b_b),
`ifdef SQUARE_CTRL_COLOR_EN
        .rgb(b_rgb),
`endif
        .state(b_st)
    );

    // Reference model: mode 0/1/2 = idle/run/pause, positions as plain integers.
    int xi [2] = '{0, 606};
    int m_mode [2];
    int m_x [2];
    int m_y [2];
    bit m_dx [2], m_dy [2], m_pend [2], m_tick [2], m_b [2], m_in [2];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic logic [26:0] expv(input int k);
        return {2'(m_mode[k]), 10'(m_x[k]), 10'(m_y[k]), m_dx[k], m_dy[k], m_in[k],
                m_tick[k], m_b[k]};
    endfunction

    task automatic mreset(input int k);
        m_mode[k] = 0; m_x[k] = xi[k]; m_y[k] = 0; m_dx[k] = 1; m_dy[k] = 1;
        m_pend[k] = 0; m_tick[k] = 0; m_b[k] = 0; m_in[k] = 0;
    endtask

    task automatic axis(inout int pos, inout bit dir, input int lim, output bit refl);
        refl = 0;
        if (dir) begin
            if (pos + SP >= lim) begin pos = lim; dir = 0; refl = 1; end
            else pos = pos + SP;
        end else begin
            if (pos <= SP) begin pos = 0; dir = 1; refl = 1; end
            else pos = pos - SP;
        end
    endtask

    task automatic mstep(input int k);
        bit upd, rx, ry;
        int ix, iy;
        ix  = int'(sx);
        iy  = int'(sy);
        upd = m_tick[k] && (m_mode[k] == 1 || (m_mode[k] == 2 && m_pend[k]));
        m_in[k] = de && ix >= m_x[k] && ix < m_x[k] + SQ && iy >= m_y[k] && iy < m_y[k] + SQ;
        m_tick[k] = (ix == 0 && iy == V);
        if (m_mode[k] == 2 && !enable) m_pend[k] = upd ? 1'b0 : (step ? 1'b1 : m_pend[k]);
        else                           m_pend[k] = 0;
        case (m_mode[k])
            0: if (enable)  m_mode[k] = 1;
            1: if (!enable) m_mode[k] = 2;
            default: if (enable) m_mode[k] = 1;
        endcase
        rx = 0; ry = 0;
        if (upd) begin
            axis(m_x[k], m_dx[k], H - SQ, rx);
            axis(m_y[k], m_dy[k], V - SQ, ry);
        end
        m_b[k] = rx || ry;
    endtask

    // One cycle: compare at the falling edge, then drive the next inputs and advance the model.
    task automatic cyc(input logic r, input logic e, input logic en, input logic st,
                       input int x, input int y);
        @(negedge clk);
        check("cycle_a", 32'(act[0]), 32'(expv(0)));
        check("cycle_b", 32'(act[1]), 32'(expv(1)));
        rst_n = r; de = e; enable = en; step = st; sx = 10'(x); sy = 10'(y);
        for (int k = 0; k < 2; k++) begin
            if (!r) mreset(k);
            else    mstep(k);
        end
    endtask

    initial begin
        int en_cur;
        int x;
        rst_n = 1'b0; de = 0; enable = 0; step = 0; sx = 0; sy = 0;
        mreset(0); mreset(1);
        cyc(0, 0, 0, 0, 5, 5);
        cyc(0, 0, 0, 0, 5, 5);
        check("reset_state", 32'(a_st), 32'd0);
        check("reset_qx_a", 32'(a_qx), 32'd0);
        check("reset_qx_b", 32'(b_qx), 32'd606);
        check("reset_dirs", {a_dx, a_dy, a_in, a_ft, a_b}, 5'b11000);

        // Run for one frame: first update gives 2,2; instance b reflects at 608.
        cyc(1, 0, 1, 0, 5, 5);
        cyc(1, 0, 1, 0, 0, V);
        cyc(1, 0, 1, 0, 5, 5);
        cyc(1, 0, 1, 0, 5, 5);
        check("run_state", 32'(a_st), 32'd1);
        check("run_qx", 32'(a_qx), 32'd2);
        check("run_qy", 32'(a_qy), 32'd2);
        check("edge_qx_b", 32'(b_qx), 32'd608);
        check("edge_dx_b", 32'(b_dx), 32'd0);
        check("edge_bounce_b", 32'(b_b), 32'd1);
        cyc(1, 0, 1, 0, 5, 5);
        check("bounce_once_b", 32'(b_b), 32'd0);

        // Pause, three steps in one frame: exactly one move, none on the following frame.
        cyc(1, 0, 0, 0, 5, 5);
        cyc(1, 0, 0, 1, 5, 5);
        cyc(1, 0, 0, 0, 5, 5);
        cyc(1, 0, 0, 1, 5, 5);
        cyc(1, 0, 0, 1, 5, 5);
        cyc(1, 0, 0, 0, 0, V);
        cyc(1, 0, 0, 0, 5, 5);
        cyc(1, 0, 0, 0, 5, 5);
        check("pause_state", 32'(a_st), 32'd2);
        check("step_qx", 32'(a_qx), 32'd4);
        check("step_qx_b", 32'(b_qx), 32'd606);
        cyc(1, 0, 0, 0, 0, V);
        cyc(1, 0, 0, 0, 5, 5);
        cyc(1, 0, 0, 0, 5, 5);
        check("no_second_step", 32'(a_qx), 32'd4);

        // Right edge of the square: column qx+31 inside, qx+32 outside.
        cyc(1, 1, 0, 0, 4 + 31, 4);
        cyc(1, 0, 0, 0, 5, 5);
        check("insq_edge_in", 32'(a_in), 32'd1);
        cyc(1, 1, 0, 0, 4 + 32, 4);
        cyc(1, 0, 0, 0, 5, 5);
        check("insq_edge_out", 32'(a_in), 32'd0);

        // Reset while frame_tick is high clears the pending update with no clock edge.
        cyc(1, 0, 1, 0, 5, 5);
        cyc(1, 0, 1, 0, 0, V);
        cyc(0, 0, 1, 0, 5, 5);
        #1;
        check("async_rst_qx", 32'(a_qx), 32'd0);
        check("async_rst_qx_b", 32'(b_qx), 32'd606);
        check("async_rst_flags", {a_b, a_ft, a_st}, 4'b0000);

        // Randomized run against the model.
        en_cur = 1;
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 199) == 0) en_cur = 1 - en_cur;
            if ($urandom_range(0, 1)) begin
                x = m_x[0] + int'($urandom_range(0, 40)) - 4;
                if (x < 0) x = 0;
            end else begin
                x = int'($urandom_range(0, 1023));
            end
            if ($urandom_range(0, 4) == 0)
                cyc(1, 0, 1'(en_cur), 1'($urandom_range(0, 7) == 0), 0, V);
            else
                cyc(($urandom_range(0, 4999) != 0), 1'($urandom_range(0, 1)), 1'(en_cur),
                    1'($urandom_range(0, 7) == 0), x,
                    m_y[0] + int'($urandom_range(0, 40)) - 4 + 4);
        end
        cyc(1, 0, 0, 0, 5, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
